// File: rtl/demux_1to2_stream_if.sv
// Handshake bundle for the 1-to-2 stream demultiplexer: one input stream,
// two output streams (A, B) and their transfer counters.
interface demux_1to2_stream_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
) ();

    logic [WIDTH-1:0]     in_data;
    logic                 select;
    logic                 in_valid;
    logic                 in_ready;

    logic [WIDTH-1:0]     a_data;
    logic                 a_valid;
    logic                 a_ready;

    logic [WIDTH-1:0]     b_data;
    logic                 b_valid;
    logic                 b_ready;

    logic [CNT_WIDTH-1:0] a_count;
    logic [CNT_WIDTH-1:0] b_count;
    logic                 cnt_clear;

    // Producer/consumer side (drives the input stream and the output readies).
    modport master (
        output in_data, select, in_valid, a_ready, b_ready, cnt_clear,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    // Demultiplexer side.
    modport slave (
        input  in_data, select, in_valid, a_ready, b_ready, cnt_clear,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

endinterface

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer: select=1 steers a beat to A, select=0
// to B; each side has a one-entry holding register and a transfer counter.
module demux_1to2_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1to2_stream_if.slave   bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } side_state_e;

    side_state_e          a_state_q, a_state_d;
    side_state_e          b_state_q, b_state_d;
    logic [WIDTH-1:0]     a_data_q,  a_data_d;
    logic [WIDTH-1:0]     b_data_q,  b_data_d;
    logic [CNT_WIDTH-1:0] a_count_q, a_count_d;
    logic [CNT_WIDTH-1:0] b_count_q, b_count_d;

    logic a_full_c, b_full_c;
    logic a_fire_c, b_fire_c;
    logic a_load_c, b_load_c;
    logic in_ready_c, in_fire_c;

    // Handshake decode; readiness looks only at the addressed side.
    always_comb begin
        a_full_c   = (a_state_q == ST_FULL);
        b_full_c   = (b_state_q == ST_FULL);
        a_fire_c   = a_full_c && bus.a_ready;
        b_fire_c   = b_full_c && bus.b_ready;
        in_ready_c = bus.select ? (!a_full_c || bus.a_ready)
                                : (!b_full_c || bus.b_ready);
        in_fire_c  = bus.in_valid && in_ready_c;
        a_load_c   = in_fire_c &&  bus.select;
        b_load_c   = in_fire_c && !bus.select;
    end

    // Side A next state: a load while draining keeps FULL with no bubble.
    always_comb begin
        a_state_d = a_state_q;
        a_data_d  = a_data_q;
        case (a_state_q)
            ST_EMPTY: begin
                if (a_load_c) begin
                    a_state_d = ST_FULL;
                    a_data_d  = bus.in_data;
                end
            end
            ST_FULL: begin
                if (a_load_c) begin
                    a_data_d  = bus.in_data;
                end else if (a_fire_c) begin
                    a_state_d = ST_EMPTY;
                end
            end
            default: a_state_d = ST_EMPTY;
        endcase
    end

    // Side B next state, mirror of side A.
    always_comb begin
        b_state_d = b_state_q;
        b_data_d  = b_data_q;
        case (b_state_q)
            ST_EMPTY: begin
                if (b_load_c) begin
                    b_state_d = ST_FULL;
                    b_data_d  = bus.in_data;
                end
            end
            ST_FULL: begin
                if (b_load_c) begin
                    b_data_d  = bus.in_data;
                end else if (b_fire_c) begin
                    b_state_d = ST_EMPTY;
                end
            end
            default: b_state_d = ST_EMPTY;
        endcase
    end

    // Transfer counters; clear wins over a same-cycle increment.
    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (bus.cnt_clear) begin
            a_count_d = '0;
            b_count_d = '0;
        end else begin
            if (a_fire_c) a_count_d = a_count_q + CNT_WIDTH'(1);
            if (b_fire_c) b_count_d = b_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state_q <= ST_EMPTY;
            b_state_q <= ST_EMPTY;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_state_q <= a_state_d;
            b_state_q <= b_state_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.a_valid  = (a_state_q == ST_FULL);
    assign bus.b_valid  = (b_state_q == ST_FULL);
    assign bus.a_data   = a_data_q;
    assign bus.b_data   = b_data_q;
    assign bus.a_count  = a_count_q;
    assign bus.b_count  = b_count_q;

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream: vector table, directed corner
// sequences and a randomized run against a per-side queue scoreboard.
module tb_demux_1to2_stream;

    logic clk;
    logic rst_n;

    demux_1to2_stream_if #(.WIDTH(8), .CNT_WIDTH(8)) bus ();

    demux_1to2_stream #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: beats held per side in acceptance order, plus fire counts.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ca;
    logic [7:0] cb;

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       ar;
        logic       br;
        logic       clr;
        logic       ir;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic [7:0] ac;
        logic [7:0] bc;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic v, input logic s, input logic [7:0] d,
                         input logic ar, input logic br, input logic clr);
        bus.in_valid  = v;
        bus.select    = s;
        bus.in_data   = d;
        bus.a_ready   = ar;
        bus.b_ready   = br;
        bus.cnt_clear = clr;
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        ca = 8'd0;
        cb = 8'd0;
    endtask

    // One clock: check outputs against the scoreboard, then advance it.
    task automatic tick(output logic ir_seen);
        logic       exp_ir, fa, fb, acc, sel, clr;
        logic [7:0] din;
        #1;
        exp_ir = bus.select ? (qa.size() == 0 || bus.a_ready)
                            : (qb.size() == 0 || bus.b_ready);
        ir_seen = bus.in_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        chk("a_valid",  32'(bus.a_valid),  32'(qa.size() != 0));
        chk("b_valid",  32'(bus.b_valid),  32'(qb.size() != 0));
        if (qa.size() != 0) chk("a_data", 32'(bus.a_data), 32'(qa[0]));
        if (qb.size() != 0) chk("b_data", 32'(bus.b_data), 32'(qb[0]));
        chk("a_count", 32'(bus.a_count), 32'(ca));
        chk("b_count", 32'(bus.b_count), 32'(cb));
        fa  = (qa.size() != 0) && bus.a_ready;
        fb  = (qb.size() != 0) && bus.b_ready;
        acc = bus.in_valid && exp_ir;
        sel = bus.select;
        din = bus.in_data;
        clr = bus.cnt_clear;
        @(posedge clk);
        #1;
        if (fa) begin void'(qa.pop_front()); ca = ca + 8'd1; end
        if (fb) begin void'(qb.pop_front()); cb = cb + 8'd1; end
        if (acc) begin
            if (sel) qa.push_back(din);
            else     qb.push_back(din);
        end
        if (clr) begin ca = 8'd0; cb = 8'd0; end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ir;
        rst_n = 1'b0;
        apply(0, 0, 8'h00, 0, 0, 0);
        model_reset();

        // Alternating stream, then clear, then back-pressure isolation on B.
        //            v  s  d      ar br clr  ir av ad     bv bd     ac    bc
        tbl[0] = '{1, 1, 8'h11, 1, 1, 0,   1, 1, 8'h11, 0, 8'h00, 8'd0, 8'd0};
        tbl[1] = '{1, 0, 8'h22, 1, 1, 0,   1, 0, 8'h00, 1, 8'h22, 8'd1, 8'd0};
        tbl[2] = '{1, 1, 8'h33, 1, 1, 0,   1, 1, 8'h33, 0, 8'h00, 8'd1, 8'd1};
        tbl[3] = '{0, 0, 8'h00, 1, 1, 0,   1, 0, 8'h00, 0, 8'h00, 8'd2, 8'd1};
        tbl[4] = '{0, 0, 8'h00, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8'd0, 8'd0};
        tbl[5] = '{1, 0, 8'h5A, 1, 0, 0,   1, 0, 8'h00, 1, 8'h5A, 8'd0, 8'd0};
        tbl[6] = '{1, 0, 8'h77, 1, 0, 0,   0, 0, 8'h00, 1, 8'h5A, 8'd0, 8'd0};
        tbl[7] = '{1, 1, 8'hC3, 1, 0, 0,   1, 1, 8'hC3, 1, 8'h5A, 8'd0, 8'd0};
        tbl[8] = '{1, 0, 8'h77, 1, 1, 0,   1, 0, 8'h00, 1, 8'h77, 8'd1, 8'd1};
        tbl[9] = '{0, 0, 8'h00, 1, 1, 0,   1, 0, 8'h00, 0, 8'h00, 8'd1, 8'd2};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_valid", 32'(bus.a_valid), 32'd0);
        chk("reset_b_valid", 32'(bus.b_valid), 32'd0);
        chk("reset_a_count", 32'(bus.a_count), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br, tbl[i].clr);
            tick(ir);
            chk($sformatf("vec%0d_in_ready", i), 32'(ir), 32'(tbl[i].ir));
            chk($sformatf("vec%0d_a_valid", i), 32'(bus.a_valid), 32'(tbl[i].av));
            chk($sformatf("vec%0d_b_valid", i), 32'(bus.b_valid), 32'(tbl[i].bv));
            if (tbl[i].av) chk($sformatf("vec%0d_a_data", i), 32'(bus.a_data), 32'(tbl[i].ad));
            if (tbl[i].bv) chk($sformatf("vec%0d_b_data", i), 32'(bus.b_data), 32'(tbl[i].bd));
            chk($sformatf("vec%0d_a_count", i), 32'(bus.a_count), 32'(tbl[i].ac));
            chk($sformatf("vec%0d_b_count", i), 32'(bus.b_count), 32'(tbl[i].bc));
        end

        // Back-to-back beats into A while it drains: no bubble.
        for (int i = 1; i <= 8; i++) begin
            apply(1, 1, 8'(i), 1, 1, 0);
            tick(ir);
            chk("stream_a_valid", 32'(bus.a_valid), 32'd1);
            chk("stream_a_data", 32'(bus.a_data), 32'(i));
        end
        apply(0, 0, 8'h00, 1, 1, 0);
        tick(ir);
        chk("stream_a_empty", 32'(bus.a_valid), 32'd0);

        // 256 fires on A wrap its counter back to 0.
        apply(0, 0, 8'h00, 1, 1, 1);
        tick(ir);
        for (int i = 0; i < 256; i++) begin
            apply(1, 1, 8'(i), 1, 1, 0);
            tick(ir);
        end
        chk("wrap_a_count_255", 32'(bus.a_count), 32'd255);
        apply(0, 0, 8'h00, 1, 1, 0);
        tick(ir);
        chk("wrap_a_count_0", 32'(bus.a_count), 32'd0);

        // Clear in the same cycle as a B fire wins over the increment.
        apply(1, 0, 8'h44, 1, 1, 0);
        tick(ir);
        apply(0, 0, 8'h00, 1, 1, 0);
        tick(ir);
        chk("clr_b_count_pre", 32'(bus.b_count), 32'd1);
        apply(1, 0, 8'h55, 1, 0, 0);
        tick(ir);
        apply(0, 0, 8'h00, 1, 1, 1);
        tick(ir);
        chk("clr_b_count", 32'(bus.b_count), 32'd0);
        chk("clr_b_valid", 32'(bus.b_valid), 32'd0);

        // Asynchronous reset with A holding a beat.
        apply(1, 1, 8'hA5, 0, 0, 0);
        tick(ir);
        apply(1, 0, 8'h5C, 0, 0, 0);
        tick(ir);
        chk("pre_rst_a_valid", 32'(bus.a_valid), 32'd1);
        chk("pre_rst_b_valid", 32'(bus.b_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("async_rst_b_valid", 32'(bus.b_valid), 32'd0);
        chk("async_rst_a_data", 32'(bus.a_data), 32'd0);
        chk("async_rst_b_data", 32'(bus.b_data), 32'd0);
        chk("async_rst_a_count", 32'(bus.a_count), 32'd0);
        chk("async_rst_b_count", 32'(bus.b_count), 32'd0);
        model_reset();
        apply(0, 1, 8'h00, 1, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(0, 1, 8'h00, 0, 0, 0);
        #1;
        chk("post_rst_in_ready_a", 32'(bus.in_ready), 32'd1);
        bus.select = 1'b0;
        #1;
        chk("post_rst_in_ready_b", 32'(bus.in_ready), 32'd1);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 63) == 0));
            tick(ir);
        end
        apply(0, 0, 8'h00, 1, 1, 0);
        repeat (2) tick(ir);
        chk("final_a_valid", 32'(bus.a_valid), 32'd0);
        chk("final_b_valid", 32'(bus.b_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
